// File: rtl/pll_reconfig_ctrl_if.sv
// Configuration request channel for pll_reconfig_ctrl: valid/ready handshake
// carrying one complete set of rPLL dynamic select codes.
interface pll_reconfig_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idsel;
  logic [5:0] cfg_fbdsel;
  logic [5:0] cfg_odsel;
  logic [3:0] cfg_dutyda;
  logic [3:0] cfg_psda;

  modport master (
    output cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_dutyda, cfg_psda,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_dutyda, cfg_psda,
    output cfg_ready
  );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// rPLL sequencer: reset pulse, lock qualification with timeout/retry, lock-loss
// recovery and dynamic divider/duty/phase reprogramming on the free-running clkin.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [5:0]  DEF_IDSEL     = 6'h3F,
  parameter logic [5:0]  DEF_FBDSEL    = 6'h3E,
  parameter logic [5:0]  DEF_ODSEL     = 6'h3C,
  parameter logic [3:0]  DEF_DUTYDA    = 4'h8,
  parameter logic [3:0]  DEF_PSDA      = 4'h0
) (
  input  logic                clkin_i,
  input  logic                reset_i,
  pll_reconfig_ctrl_if.slave  cfg,
  input  logic                pll_lock_i,
  output logic                pll_reset_o,
  output logic [5:0]          pll_idsel_o,
  output logic [5:0]          pll_fbdsel_o,
  output logic [5:0]          pll_odsel_o,
  output logic [3:0]          pll_dutyda_o,
  output logic [3:0]          pll_psda_o,
  output logic                sys_rst_o,
  output logic                locked_o,
  output logic                fault_o,
  output logic [3:0]          retry_cnt_o
);

  typedef enum logic [1:0] {
    ST_RST_HOLD  = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  // Timer covers both the reset pulse and the lock timeout; filter covers stable and loss runs.
  localparam int unsigned TMAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned FMAX = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam int unsigned FW   = (FMAX < 2) ? 1 : $clog2(FMAX);

  localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] STABLE_LAST = FW'(STABLE_CYCLES - 1);
  localparam logic [FW-1:0] LOSS_LAST   = FW'(LOSS_FILTER - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic [3:0]    dutyda_q, dutyda_d, psda_q, psda_d;
  logic          lock_meta_q, lock_s_q;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_q, sys_rst_d;
  logic          locked_q, locked_d;
  logic          fault_q, fault_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          accept;

  assign accept    = cfg.cfg_valid & cfg_ready_q;
  assign retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

  always_ff @(posedge clkin_i) begin
    if (reset_i) begin
      state_q     <= ST_RST_HOLD;
      tmr_q       <= '0;
      filt_q      <= '0;
      retry_q     <= '0;
      idsel_q     <= DEF_IDSEL;
      fbdsel_q    <= DEF_FBDSEL;
      odsel_q     <= DEF_ODSEL;
      dutyda_q    <= DEF_DUTYDA;
      psda_q      <= DEF_PSDA;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      filt_q      <= filt_d;
      retry_q     <= retry_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      dutyda_q    <= dutyda_d;
      psda_q      <= psda_d;
      lock_meta_q <= pll_lock_i;
      lock_s_q    <= lock_meta_q;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    filt_d   = filt_q;
    retry_d  = retry_q;
    idsel_d  = idsel_q;
    fbdsel_d = fbdsel_q;
    odsel_d  = odsel_q;
    dutyda_d = dutyda_q;
    psda_d   = psda_q;

    unique case (state_q)
      ST_RST_HOLD: begin
        if (tmr_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          tmr_d   = '0;
          filt_d  = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q && (filt_q == STABLE_LAST)) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          filt_d  = '0;
        end else if (tmr_q == TMO_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RETRY_MAX) ? ST_RST_HOLD : ST_FAULT;
          tmr_d   = '0;
          filt_d  = '0;
        end else begin
          tmr_d  = tmr_q + 1'b1;
          filt_d = lock_s_q ? filt_q + 1'b1 : '0;
        end
      end
      ST_LOCKED: begin
        if (!lock_s_q && (filt_q == LOSS_LAST)) begin
          state_d = ST_RST_HOLD;
          tmr_d   = '0;
          filt_d  = '0;
        end else begin
          filt_d = lock_s_q ? '0 : filt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // An accepted request overrides whatever the lock-loss filter decided this cycle.
    if (accept) begin
      state_d  = ST_RST_HOLD;
      tmr_d    = '0;
      filt_d   = '0;
      retry_d  = '0;
      idsel_d  = cfg.cfg_idsel;
      fbdsel_d = cfg.cfg_fbdsel;
      odsel_d  = cfg.cfg_odsel;
      dutyda_d = cfg.cfg_dutyda;
      psda_d   = cfg.cfg_psda;
    end
  end

  always_comb begin
    pll_reset_d = 1'b1;
    sys_rst_d   = 1'b1;
    locked_d    = 1'b0;
    fault_d     = 1'b0;
    cfg_ready_d = 1'b0;
    unique case (state_d)
      ST_WAIT_LOCK: pll_reset_d = 1'b0;
      ST_LOCKED: begin
        pll_reset_d = 1'b0;
        sys_rst_d   = 1'b0;
        locked_d    = 1'b1;
        cfg_ready_d = 1'b1;
      end
      ST_FAULT: begin
        fault_d     = 1'b1;
        cfg_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign pll_reset_o   = pll_reset_q;
  assign pll_idsel_o   = idsel_q;
  assign pll_fbdsel_o  = fbdsel_q;
  assign pll_odsel_o   = odsel_q;
  assign pll_dutyda_o  = dutyda_q;
  assign pll_psda_o    = psda_q;
  assign sys_rst_o     = sys_rst_q;
  assign locked_o      = locked_q;
  assign fault_o       = fault_q;
  assign retry_cnt_o   = retry_q;

endmodule
